ifetch_queue: RTL

Instruction-fetch stage sitting directly downstream of the PC register. It takes the current PC, issues one request at a time to a variable-latency instruction memory, and buffers returned {pc, instruction} pairs in a small FIFO for the IF/ID stage. It produces the stall that holds the PC until the fetch for the current PC has been accepted. It also discards in-flight and buffered fetches on a branch/jump flush.

---
 rtl/ifq_pkg.sv | 23 ++
 rtl/ifq_fifo.sv | 47 ++++
 rtl/ifetch_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// Shared types and reset constants for the instruction-fetch queue.
// Entries carry the fetch PC alongside the returned instruction word.
package ifq_pkg;

  localparam int IFQ_PC_W   = 32;
  localparam int IFQ_INST_W = 32;

  typedef enum logic [1:0] {
    IFQ_IDLE,
    IFQ_REQ,
    IFQ_DRAIN
  } ifq_state_e;

  typedef struct packed {
    logic [IFQ_PC_W-1:0]   pc;
    logic [IFQ_INST_W-1:0] inst;
  } ifq_entry_t;

  localparam ifq_state_e IFQ_RST_STATE = IFQ_IDLE;
  localparam logic       IFQ_RST_REQ   = 1'b0;
  localparam ifq_entry_t IFQ_RST_ENTRY = '0;

endpackage

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO of fetch entries with wrap-bit pointers.
// clear wins over push and pop; head reads as zero when empty.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       push_i,
  input  ifq_entry_t data_i,
  input  logic       pop_i,
  output logic [CW-1:0] count_o,
  output logic       valid_o,
  output ifq_entry_t head_o
);

  ifq_entry_t    mem [DEPTH];
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;

  // Pointer update; a clear or reset empties the queue immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_i) wptr <= wptr + 1'b1;
      if (pop_i)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; data is only meaningful behind the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i && !rst_i)
      mem[wptr[AW-1:0]] <= data_i;
  end

  assign count_o = wptr - rptr;
  assign valid_o = (wptr != rptr);
  assign head_o  = valid_o ? mem[rptr[AW-1:0]]
                           : IFQ_RST_ENTRY;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: one outstanding imem request, buffered responses.
// Optional same-cycle response bypass under IFQ_BYPASS_EN.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              id_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e    state;
  logic [CW-1:0] cnt;
  logic          fifo_valid;
  ifq_entry_t    head;
  ifq_entry_t    wr;
  logic          acc_ack;
  logic          can_issue;
  logic          push;
  logic          pop;
  logic          byp;

  assign acc_ack = (state == IFQ_REQ) && imem_ack_i
                && !flush_i && !rst_i;

  assign can_issue = pc_valid_i && !flush_i
                  && (cnt < CW'(DEPTH));

  assign stall_o = !(acc_ack || flush_i);

  assign wr.pc   = IFQ_PC_W'(imem_addr_o);
  assign wr.inst = imem_data_i;

  assign pop = fifo_valid && id_ready_i;

`ifdef IFQ_BYPASS_EN
  assign byp  = acc_ack && !fifo_valid;
  assign push = acc_ack && !(byp && id_ready_i);
`else
  assign byp  = 1'b0;
  assign push = acc_ack;
`endif

  // Request FSM: issue, wait for ack, swallow acks after a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IFQ_RST_STATE;
      imem_req_o  <= IFQ_RST_REQ;
      imem_addr_o <= '0;
    end else begin
      unique case (state)
        IFQ_IDLE: begin
          if (can_issue) begin
            imem_addr_o <= pc_i;
            imem_req_o  <= 1'b1;
            state       <= IFQ_REQ;
          end
        end
        IFQ_REQ: begin
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state      <= IFQ_IDLE;
          end else if (flush_i) begin
            state <= IFQ_DRAIN;
          end
        end
        IFQ_DRAIN: begin
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state      <= IFQ_IDLE;
          end
        end
        default: begin
          imem_req_o <= 1'b0;
          state      <= IFQ_IDLE;
        end
      endcase
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .push_i  (push),
    .data_i  (wr),
    .pop_i   (pop),
    .count_o (cnt),
    .valid_o (fifo_valid),
    .head_o  (head)
  );

  // Head presentation, taking the live response when bypassing.
  always_comb begin
    inst_valid_o = fifo_valid;
    inst_o       = head.inst;
    inst_pc_o    = ADDR_W'(head.pc);
    if (byp) begin
      inst_valid_o = 1'b1;
      inst_o       = imem_data_i;
      inst_pc_o    = imem_addr_o;
    end
  end

endmodule
